wptr_ctrl: RTL

Write-side pointer and status controller for the asynchronous FIFO, in the write clock domain. It is a parametrised successor to the basic write-pointer handler and adds:
- internal Gray-to-binary conversion of the synchronised read pointer
- registered fill level, almost-full threshold and sticky overflow flag
- a direct RAM write address

It drives the FIFO memory write port and the Gray pointer that crosses into the read domain.

---
 rtl/wptr_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/wptr_ctrl.sv
// ----------------------------------------------------------------------------
// wptr_ctrl
//   Write-side pointer and status controller for an asynchronous FIFO. All of
//   its state is in the write clock domain. It converts the synchronised Gray
//   read pointer back to binary, keeps a registered fill level and full /
//   almost-full flags, and holds a sticky overflow flag. It produces the RAM
//   write address and write enable, and the Gray write pointer that crosses
//   into the read domain.
//
// Parameters
//   PTR_WIDTH : RAM address width. DEPTH = 2**PTR_WIDTH. Pointers carry one
//               extra wrap bit.
//   AF_TH     : almost-full threshold in entries, 1..DEPTH.
//
// Ports
//   wclk        in  : write clock; all state changes on the rising edge
//   wrst        in  : synchronous active-high reset
//   w_en        in  : write request
//   ovf_clr     in  : clears the sticky overflow flag
//   g_rptr_sync in  : Gray read pointer, already synchronised into wclk
//   b_wptr      out : binary write pointer
//   g_wptr      out : registered Gray write pointer, for the read domain
//   waddr       out : RAM write address (low bits of b_wptr)
//   w_accept    out : RAM write enable for this cycle (w_en & !full)
//   full        out : FIFO full
//   almost_full out : fill level >= AF_TH
//   wlevel      out : fill level seen from the write side, 0..DEPTH
//   overflow    out : sticky; a write was attempted while full
// ----------------------------------------------------------------------------
module wptr_ctrl #(
    parameter int PTR_WIDTH = 3,
    parameter int AF_TH     = 6
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 w_en,
    input  logic                 ovf_clr,
    input  logic [PTR_WIDTH:0]   g_rptr_sync,
    output logic [PTR_WIDTH:0]   b_wptr,
    output logic [PTR_WIDTH:0]   g_wptr,
    output logic [PTR_WIDTH-1:0] waddr,
    output logic                 w_accept,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   wlevel,
    output logic                 overflow
);

    localparam int               DEPTH   = 1 << PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] DEPTH_V = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] AF_V    = (PTR_WIDTH+1)'(AF_TH);

    // Gray to binary: the MSB passes through, and each lower bit is the XOR
    // of the binary bit above it with its own Gray bit.
    function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
        logic [PTR_WIDTH:0] b;
        b[PTR_WIDTH] = g[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PTR_WIDTH:0] b_rptr_sync;
    logic [PTR_WIDTH:0] b_wptr_next;
    logic [PTR_WIDTH:0] g_wptr_next;
    logic [PTR_WIDTH:0] level_next;

    assign w_accept = w_en & ~full;
    assign waddr    = b_wptr[PTR_WIDTH-1:0];

    // Next-state values. The subtraction wraps modulo 2**(PTR_WIDTH+1). The
    // extra wrap bit lets a level of exactly DEPTH be told apart from empty.
    always_comb begin
        b_rptr_sync = gray2bin(g_rptr_sync);
        b_wptr_next = b_wptr + {{PTR_WIDTH{1'b0}}, w_accept};
        g_wptr_next = b_wptr_next ^ (b_wptr_next >> 1);
        level_next  = b_wptr_next - b_rptr_sync;
    end

    // Register stage: pointers, level and flags all update together. The
    // flags are taken from level_next, so they are never a cycle late
    // relative to wlevel.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            b_wptr      <= '0;
            g_wptr      <= '0;
            wlevel      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            b_wptr      <= b_wptr_next;
            g_wptr      <= g_wptr_next;
            wlevel      <= level_next;
            full        <= (level_next == DEPTH_V);
            almost_full <= (level_next >= AF_V);
            // If a write is rejected while ovf_clr is high, the set takes
            // priority, so that overflow event is not lost.
            if (w_en & full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
